// File: rtl/mul_fxp_pkg.sv
// Shared types and helpers for the fixed-point multiplier family.
// Holds the FSM encoding, rounding modes and a sign-magnitude helper.
package mul_fxp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  localparam int MAG_W = 64;

  // Callers sign-extend into MAG_W and cast the result back down.
  function automatic logic [MAG_W-1:0] abs_mag(
    input logic signed [MAG_W-1:0] v
  );
    logic [MAG_W-1:0] r;
    r = v[MAG_W-1] ? MAG_W'(-v) : MAG_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/mul_fxp_round_sat.sv
// Magnitude rounding, sign application and saturation of a product.
// Purely combinational so an accumulator can feed it directly.
module mul_fxp_round_sat
  import mul_fxp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 13
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic                sign,
  input  logic                rnd,
  output logic [DATA_W-1:0]   product,
  output logic                ovf
);

  localparam int AW = 2 * DATA_W;

  localparam logic [AW-1:0] MAXP =
    {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [AW-1:0] MAXN =
    AW'(1) << (DATA_W - 1);

  logic [AW-1:0]     sum;
  logic [AW-1:0]     mag;
  logic [DATA_W-1:0] mag_lo;

  if (FRAC_W > 0) begin : g_rnd
    localparam logic [AW-1:0] HALF =
      AW'(1) << (FRAC_W - 1);
    assign sum = acc + ((rnd == RND_HALF_UP) ? HALF : '0);
  end else begin : g_nornd
    assign sum = acc;
  end

  assign mag    = sum >> FRAC_W;
  assign mag_lo = mag[DATA_W-1:0];

  always_comb begin
    product = '0;
    ovf     = 1'b0;
    if (!sign) begin
      if (mag > MAXP) begin
        product = {1'b0, {(DATA_W-1){1'b1}}};
        ovf     = 1'b1;
      end else begin
        product = mag_lo;
      end
    end else begin
      if (mag > MAXN) begin
        product = {1'b1, {(DATA_W-1){1'b0}}};
        ovf     = 1'b1;
      end else begin
        product = -mag_lo;
      end
    end
  end

endmodule

// File: rtl/mul_fxp_seq.sv
// Signed fixed-point digit-serial multiplier with valid/ready on both
// sides; terminates as soon as the remaining multiplier is zero.
module mul_fxp_seq
  import mul_fxp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 13,
  parameter int DIGIT_W = 5
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  output logic              O_RDY,
  input  logic [DATA_W-1:0] I_M1,
  input  logic [DATA_W-1:0] I_M2,
  input  logic              I_RND,
  output logic              O_VLD,
  input  logic              I_RDY,
  output logic [DATA_W-1:0] O_PRODUCT,
  output logic              O_OVF
);

  localparam int AW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [AW-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              sign_q, sign_d;
  logic              rnd_q, rnd_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic              ovf_q, ovf_d;

  logic [AW-1:0]     digit;
  logic [DATA_W-1:0] rs_prod;
  logic              rs_ovf;

  assign digit = AW'(mplier_q[DIGIT_W-1:0]);

  mul_fxp_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc     (acc_q),
    .sign    (sign_q),
    .rnd     (rnd_q),
    .product (rs_prod),
    .ovf     (rs_ovf)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    rnd_d    = rnd_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (I_VLD) begin
          mcand_d  = AW'(abs_mag(MAG_W'($signed(I_M1))));
          mplier_d = DATA_W'(abs_mag(MAG_W'($signed(I_M2))));
          sign_d   = I_M1[DATA_W-1] ^ I_M2[DATA_W-1];
          rnd_d    = I_RND;
          acc_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q == '0) begin
          prod_d  = rs_prod;
          ovf_d   = rs_ovf;
          state_d = OUT;
        end else begin
          acc_d    = acc_q + mcand_q * digit;
          mcand_d  = mcand_q << DIGIT_W;
          mplier_d = mplier_q >> DIGIT_W;
        end
      end
      OUT: begin
        if (I_RDY) begin
          prod_d  = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      rnd_q    <= RND_TRUNC;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      rnd_q    <= rnd_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign O_RDY     = (state_q == IDLE);
  assign O_VLD     = (state_q == OUT);
  assign O_PRODUCT = prod_q;
  assign O_OVF     = ovf_q;

endmodule
